// File: rtl/shift_pkg.sv
// shift_pkg: shared op codes and FSM state encoding for the shift units.
// No ports; imported by shift_step and iter_shifter (and the single-cycle shifter).
package shift_pkg;
    localparam logic [1:0] SHIFT_LEFT             = 2'd0;
    localparam logic [1:0] SHIFT_RIGHT_LOGICAL    = 2'd1;
    localparam logic [1:0] SHIFT_RIGHT_ARITHMETIC = 2'd2;
    localparam logic [1:0] SHIFT_ROTATE_RIGHT     = 2'd3;
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;
endpackage

// File: rtl/shift_step.sv
// shift_step: one combinational iteration of the iterative shifter.
// Ports: data_i operand, op_i shift op, k_i bits to shift this iteration (0..8), res_o shifted result.
module shift_step
    import shift_pkg::*;
(
    input  logic [31:0] data_i,
    input  logic [1:0]  op_i,
    input  logic [3:0]  k_i,
    output logic [31:0] res_o
);
    // Kept in its own signed net so the arithmetic shift is not turned logical by an unsigned mux context
    logic signed [31:0] sra;
    assign sra = $signed(data_i) >>> k_i;
    assign res_o = (op_i == SHIFT_LEFT)             ? data_i << k_i :
                   (op_i == SHIFT_RIGHT_LOGICAL)    ? data_i >> k_i :
                   (op_i == SHIFT_RIGHT_ARITHMETIC) ? sra :
                   (data_i >> k_i) | (data_i << (6'd32 - {2'b00, k_i}));
endmodule

// File: rtl/iter_shifter.sv
// iter_shifter: multi-cycle shift/rotate unit, up to STEP bits per BUSY cycle.
// Ports: clk, rst_n (async active-low); in_valid/in_ready/in_a/in_b/shift_op request side;
//        flush sync abort; out_valid/out_ready/out registered result side.
module iter_shifter
    import shift_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int STEP  = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [31:0]      in_b,
    input  logic [1:0]       shift_op,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out
);
    state_e      state_q;
    logic [31:0] data_q, data_d;
    logic [1:0]  op_q;
    logic [4:0]  rem_q, rem_d;
    logic [3:0]  k;
    logic        in_ready_q, out_valid_q;
    logic        unused_b;
    assign unused_b = ^in_b[31:5];
    assign k = (rem_q < 5'(STEP)) ? rem_q[3:0] : 4'(STEP);
    assign rem_d = rem_q - {1'b0, k};
    shift_step u_step (
        .data_i(data_q),
        .op_i  (op_q),
        .k_i   (k),
        .res_o (data_d)
    );
    // The result register doubles as the working data register; it only changes outside DONE
    assign out       = data_q;
    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            data_q      <= '0;
            op_q        <= SHIFT_LEFT;
            rem_q       <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else if (flush) begin
            state_q     <= ST_IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    in_ready_q <= 1'b1;
                    if (in_valid && in_ready_q) begin
                        data_q     <= in_a;
                        op_q       <= shift_op;
                        rem_q      <= in_b[4:0];
                        in_ready_q <= 1'b0;
                        if (in_b[4:0] == 5'd0) begin
                            state_q     <= ST_DONE;
                            out_valid_q <= 1'b1;
                        end else begin
                            state_q <= ST_BUSY;
                        end
                    end
                end
                ST_BUSY: begin
                    data_q <= data_d;
                    rem_q  <= rem_d;
                    if (rem_d == 5'd0) begin
                        state_q     <= ST_DONE;
                        out_valid_q <= 1'b1;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state_q     <= ST_IDLE;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_iter_shifter.sv
// tb_iter_shifter: randomized self-checking bench for iter_shifter at STEP=1 and STEP=4.
module tb_iter_shifter;
    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        in_valid = 1'b0;
    logic        flush = 1'b0;
    logic        out_ready = 1'b1;
    logic [31:0] in_a = '0;
    logic [31:0] in_b = '0;
    logic [1:0]  shift_op = '0;
    logic [1:0]  rdy, vld;
    logic [1:0][31:0] res;
    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    iter_shifter #(.WIDTH(32), .STEP(1)) u_s1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy[0]),
        .in_a(in_a), .in_b(in_b), .shift_op(shift_op), .flush(flush),
        .out_valid(vld[0]), .out_ready(out_ready), .out(res[0])
    );
    iter_shifter #(.WIDTH(32), .STEP(4)) u_s4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy[1]),
        .in_a(in_a), .in_b(in_b), .shift_op(shift_op), .flush(flush),
        .out_valid(vld[1]), .out_ready(out_ready), .out(res[1])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int step_of(input int i);
        return (i == 0) ? 1 : 4;
    endfunction

    // Reference: shift amount is the operand amount modulo 32, result from plain operators
    function automatic logic [31:0] ref_shift(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op);
        int amt;
        logic [63:0] w;
        amt = int'(b % 32);
        w = {a, a};
        case (op)
            2'd0: return a << amt;
            2'd1: return a >> amt;
            2'd2: return 32'($signed(a) >>> amt);
            default: return w[amt +: 32];
        endcase
    endfunction

    function automatic int ref_lat(input logic [31:0] b, input int s);
        int amt;
        amt = int'(b % 32);
        return 1 + (amt + s - 1) / s;
    endfunction

    task automatic wait_ready();
        int w;
        w = 0;
        while (rdy !== 2'b11 && w < 60) begin
            @(negedge clk);
            w++;
        end
        check("idle_ready", {30'b0, rdy}, 32'd3);
    endtask

    task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op);
        int lat[2];
        logic [31:0] got[2];
        lat[0] = 0;
        lat[1] = 0;
        got[0] = '0;
        got[1] = '0;
        wait_ready();
        in_valid = 1'b1;
        in_a = a;
        in_b = b;
        shift_op = op;
        @(negedge clk);
        in_valid = 1'b0;
        in_a = $urandom;
        in_b = $urandom;
        shift_op = 2'($urandom);
        for (int n = 1; n <= 40; n++) begin
            for (int i = 0; i < 2; i++) begin
                if (lat[i] == 0 && vld[i]) begin
                    lat[i] = n;
                    got[i] = res[i];
                end else if (lat[i] != 0 && n == lat[i] + 1) begin
                    check("valid_one_cycle", {31'b0, vld[i]}, 32'd0);
                    check("ready_after_done", {31'b0, rdy[i]}, 32'd1);
                end
            end
            if (n < 40) @(negedge clk);
        end
        for (int i = 0; i < 2; i++) begin
            check($sformatf("latency s%0d op%0d amt%0d", step_of(i), op, b % 32), 32'(lat[i]), 32'(ref_lat(b, step_of(i))));
            check($sformatf("result s%0d op%0d a=%h b=%0d", step_of(i), op, a, b), got[i], ref_shift(a, b, op));
        end
    endtask

    initial begin
        logic [31:0] hold0, hold1, exp_bp;
        logic any_v;
        // reset state
        #1 rst_n = 1'b0;
        #2;
        check("rst_out0", res[0], 32'd0);
        check("rst_out1", res[1], 32'd0);
        check("rst_valid", {30'b0, vld}, 32'd0);
        repeat (3) @(negedge clk);
        check("rst_ready_low", {30'b0, rdy}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("ready_after_rst", {30'b0, rdy}, 32'd3);
        check("valid_after_rst", {30'b0, vld}, 32'd0);
        // directed cases
        do_op(32'h8000_0000, 32'd4, 2'd2);
        do_op(32'h0000_0001, 32'd31, 2'd0);
        do_op(32'h0000_0001, 32'd37, 2'd0);
        do_op(32'hDEAD_BEEF, 32'd32, 2'd1);
        do_op(32'h1234_5678, 32'd8, 2'd3);
        do_op(32'h8000_0000, 32'd31, 2'd1);
        do_op(32'h8765_4321, 32'd0, 2'd2);
        // random cases
        for (int r = 0; r < 40; r++) begin
            do_op($urandom, (r % 3 == 0) ? 32'($urandom_range(0, 40)) : $urandom, 2'($urandom));
        end
        // backpressure
        wait_ready();
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_a = 32'hC0DE_1234;
        in_b = 32'd9;
        shift_op = 2'd3;
        exp_bp = ref_shift(32'hC0DE_1234, 32'd9, 2'd3);
        @(negedge clk);
        in_valid = 1'b0;
        for (int w = 0; w < 40 && vld !== 2'b11; w++) @(negedge clk);
        check("bp_valid", {30'b0, vld}, 32'd3);
        hold0 = res[0];
        hold1 = res[1];
        check("bp_result0", hold0, exp_bp);
        check("bp_result1", hold1, exp_bp);
        for (int c = 0; c < 5; c++) begin
            in_valid = 1'b1;
            in_a = $urandom;
            in_b = 32'($urandom_range(1, 31));
            shift_op = 2'($urandom);
            @(negedge clk);
            check("bp_hold_out0", res[0], exp_bp);
            check("bp_hold_out1", res[1], exp_bp);
            check("bp_hold_valid", {30'b0, vld}, 32'd3);
            check("bp_ready_low", {30'b0, rdy}, 32'd0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_release_valid", {30'b0, vld}, 32'd0);
        check("bp_release_ready", {30'b0, rdy}, 32'd3);
        // flush in the third BUSY cycle
        wait_ready();
        in_valid = 1'b1;
        in_a = 32'h0000_00FF;
        in_b = 32'd20;
        shift_op = 2'd0;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_ready", {30'b0, rdy}, 32'd3);
        check("flush_valid", {30'b0, vld}, 32'd0);
        any_v = 1'b0;
        repeat (30) begin
            @(negedge clk);
            any_v |= |vld;
        end
        check("flush_no_valid", {31'b0, any_v}, 32'd0);
        // flush together with a request in IDLE
        in_valid = 1'b1;
        flush = 1'b1;
        in_b = 32'd0;
        @(negedge clk);
        in_valid = 1'b0;
        flush = 1'b0;
        check("flush_req_ready", {30'b0, rdy}, 32'd3);
        any_v = 1'b0;
        repeat (10) begin
            @(negedge clk);
            any_v |= |vld;
        end
        check("flush_req_ignored", {31'b0, any_v}, 32'd0);
        // reset mid-BUSY
        do_op(32'h1111_2222, 32'd3, 2'd1);
        wait_ready();
        in_valid = 1'b1;
        in_a = 32'hFFFF_0000;
        in_b = 32'd20;
        shift_op = 2'd1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_out0", res[0], 32'd0);
        check("async_rst_out1", res[1], 32'd0);
        check("async_rst_valid", {30'b0, vld}, 32'd0);
        check("async_rst_ready", {30'b0, rdy}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rerst_ready", {30'b0, rdy}, 32'd3);
        check("rerst_valid", {30'b0, vld}, 32'd0);
        do_op(32'h8000_00F0, 32'd13, 2'd2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
